// File: rtl/flat_packer_if.sv
// Output word stream of flat_packer: valid/ready handshake with an end-of-map marker.
interface flat_packer_if #(
  parameter int WORD = 32
);
  logic [WORD-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/flat_packer.sv
// Captures one flattened DIM x DIM feature map and streams its m x n region as
// row-aligned, zero-padded WORD-bit words over a valid/ready interface.
module flat_packer #(
  parameter int BITS = 8,
  parameter int DIM  = 32,
  parameter int WORD = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(DIM):0]         m,
  input  logic [$clog2(DIM):0]         n,
  input  logic [DIM*DIM-1:0][BITS-1:0] IN,
  flat_packer_if.master                out_if,
  output logic                         busy,
  output logic                         done
);
  localparam int PPW = WORD / BITS;
  localparam int CW  = $clog2(DIM) + 1;
  localparam int IW  = $clog2(DIM*DIM) + 1;
  localparam int AW  = $clog2(DIM*DIM);
  localparam logic [CW-1:0] DIM_C = CW'(DIM);

  typedef logic [DIM*DIM-1:0][BITS-1:0] map_t;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state_q;
  map_t            buf_q;
  logic [CW-1:0]   m_q, n_q, wpr_q, row_q, wcol_q;
  logic [WORD-1:0] data_q;
  logic            valid_q, last_q, busy_q, done_q;

  logic [CW-1:0]   m_cl, n_cl, wpr_cl, row_d, wcol_d;
  logic [WORD-1:0] first_word, next_word;
  logic            accept;

  function automatic logic [WORD-1:0] pack_word(map_t src, logic [CW-1:0] row,
                                                logic [CW-1:0] wcol, logic [CW-1:0] ncols);
    logic [WORD-1:0] w;
    logic [IW-1:0]   col;
    logic [AW-1:0]   idx;
    w = '0;
    for (int j = 0; j < PPW; j++) begin
      col = IW'(wcol) * IW'(PPW) + IW'(j);
      idx = AW'(col + IW'(row) * IW'(DIM));
      if (col < IW'(ncols) && col < IW'(DIM)) w[j*BITS +: BITS] = src[idx];
    end
    return w;
  endfunction

  assign m_cl   = (m > DIM_C) ? DIM_C : m;
  assign n_cl   = (n > DIM_C) ? DIM_C : n;
  assign wpr_cl = CW'((int'(n_cl) + PPW - 1) / PPW);
  assign accept = valid_q && out_if.out_ready;

  always_comb begin
    row_d  = row_q;
    wcol_d = wcol_q + CW'(1);
    if (wcol_q == wpr_q - CW'(1)) begin
      wcol_d = '0;
      row_d  = row_q + CW'(1);
    end
  end

  // The first word comes straight from IN because the buffer is loaded on the same edge.
  assign first_word = pack_word(IN, '0, '0, n_cl);
  assign next_word  = pack_word(buf_q, row_d, wcol_d, n_q);

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) buf_q <= IN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      n_q     <= '0;
      wpr_q   <= '0;
      row_q   <= '0;
      wcol_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          busy_q <= start;
          if (start) begin
            m_q    <= m_cl;
            n_q    <= n_cl;
            wpr_q  <= wpr_cl;
            row_q  <= '0;
            wcol_q <= '0;
            if (m_cl == '0 || n_cl == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= STREAM;
              valid_q <= 1'b1;
              data_q  <= first_word;
              last_q  <= (m_cl == CW'(1)) && (wpr_cl == CW'(1));
            end
          end
        end
        STREAM: begin
          busy_q <= 1'b1;
          if (accept) begin
            if (last_q) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              data_q  <= '0;
            end else begin
              row_q  <= row_d;
              wcol_q <= wcol_d;
              data_q <= next_word;
              last_q <= (row_d == m_q - CW'(1)) && (wcol_d == wpr_q - CW'(1));
            end
          end
        end
        DONE: begin
          // busy stays up through the registered done pulse that follows.
          busy_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign busy             = busy_q;
  assign done             = done_q;
endmodule

// File: tb/tb_flat_packer.sv
// Self-checking bench for flat_packer: table-driven maps with a word scoreboard,
// plus hand-written reset-abort and single-pixel sequences.
module tb_flat_packer;
  localparam int BITS = 8;
  localparam int DIM  = 32;
  localparam int WORD = 32;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         start = 1'b0;
  logic [5:0]                   m_in = '0;
  logic [5:0]                   n_in = '0;
  logic [DIM*DIM-1:0][BITS-1:0] in_map;
  logic                         busy, done;

  flat_packer_if #(.WORD(WORD)) bus ();

  flat_packer #(.BITS(BITS), .DIM(DIM), .WORD(WORD)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m_in), .n(n_in), .IN(in_map),
    .out_if(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m, n, pat, rmode, mid_start, exp_words, exp_done, chk_words;
    logic [31:0] first, lastw;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [32:0] expq[$];
  logic [32:0] mon_e;
  int          run_words = 0;
  logic [31:0] seen_first, seen_last;
  logic        stall_pend = 1'b0;
  logic [32:0] stall_val;
  vec_t        vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a word seen with ready high at the falling edge is taken on the next rise.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else if (bus.out_valid) begin
      if (stall_pend) chk("stall_hold", 64'({bus.out_last, bus.out_data}), 64'(stall_val));
      if (bus.out_ready) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: got %h, expected no word", bus.out_data);
        end else begin
          mon_e = expq.pop_front();
          chk("word", 64'({bus.out_last, bus.out_data}), 64'(mon_e));
        end
        if (run_words == 0) seen_first = bus.out_data;
        seen_last  = bus.out_data;
        run_words++;
        stall_pend = 1'b0;
      end else begin
        stall_pend = 1'b1;
        stall_val  = {bus.out_last, bus.out_data};
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  function automatic logic [31:0] model_word(int r, int k, int nc);
    logic [31:0] w;
    int col;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      col = k * 4 + j;
      if (col < nc) w[j*8 +: 8] = in_map[r*32 + col];
    end
    return w;
  endfunction

  task automatic fill(input int pat);
    for (int i = 0; i < DIM*DIM; i++) begin
      case (pat)
        0: in_map[i] = 8'((i / 32) * 16 + (i % 32));
        1: in_map[i] = 8'(i + 1);
        2: in_map[i] = 8'hFF;
        3: in_map[i] = 8'($urandom);
        default: ;
      endcase
    end
  endtask

  task automatic push_expected(input int m, input int n);
    int mc, nc, wpr;
    mc  = (m > 32) ? 32 : m;
    nc  = (n > 32) ? 32 : n;
    wpr = (nc + 3) / 4;
    for (int r = 0; r < mc; r++)
      for (int k = 0; k < wpr; k++)
        expq.push_back({(r == mc - 1 && k == wpr - 1), model_word(r, k, nc)});
  endtask

  task automatic run_map(input vec_t v);
    int cyc, dcyc, budget;
    fill(v.pat);
    push_expected(v.m, v.n);
    run_words = 0;
    budget    = v.exp_words * 8 + 40;
    m_in  = 6'(v.m);
    n_in  = 6'(v.n);
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    in_map = ~in_map;
    cyc  = 1;
    dcyc = 0;
    while (cyc <= budget) begin
      if (cyc == 1) chk("busy_after_start", 64'(busy), 64'(1));
      case (v.rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((cyc - 1) % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      start = (v.mid_start != 0 && cyc == 2);
      if (done && dcyc == 0) begin
        dcyc = cyc;
        chk("busy_at_done", 64'(busy), 64'(1));
      end
      if (dcyc != 0 && cyc == dcyc + 1) begin
        chk("done_single_cycle", 64'(done), 64'(0));
        chk("busy_drop", 64'(busy), 64'(0));
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    if (dcyc == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
    end
    chk("word_count", 64'(run_words), 64'(v.exp_words));
    chk("queue_empty", 64'(expq.size()), 64'(0));
    expq.delete();
    if (v.exp_done != 0) chk("done_cycle", 64'(dcyc), 64'(v.exp_done));
    if (v.chk_words != 0) begin
      chk("first_word", 64'(seen_first), 64'(v.first));
      chk("last_word", 64'(seen_last), 64'(v.lastw));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ndone, nvalid;
    vec_t hv;
    vecs[0] = '{2, 4, 0, 0, 0, 2, 4, 1, 32'h03020100, 32'h13121110};
    vecs[1] = '{1, 5, 1, 0, 0, 2, 4, 1, 32'h04030201, 32'h00000005};
    vecs[2] = '{3, 32, 3, 1, 0, 24, 72, 0, 32'h0, 32'h0};
    vecs[3] = '{0, 7, 3, 0, 0, 0, 2, 0, 32'h0, 32'h0};
    vecs[4] = '{40, 40, 2, 0, 0, 256, 258, 1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5] = '{5, 13, 3, 2, 0, 20, 0, 0, 32'h0, 32'h0};
    vecs[6] = '{7, 0, 3, 0, 0, 0, 2, 0, 32'h0, 32'h0};
    vecs[7] = '{32, 1, 0, 0, 0, 32, 34, 1, 32'h00000000, 32'h000000F0};
    vecs[8] = '{2, 8, 0, 1, 1, 4, 12, 1, 32'h03020100, 32'h17161514};

    in_map = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_last", 64'(bus.out_last), 64'(0));
    chk("rst_data", 64'(bus.out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_map(vecs[i]);

    // Abort a 16-word map after three accepted words.
    fill(3);
    push_expected(2, 32);
    run_words = 0;
    m_in  = 6'd2;
    n_in  = 6'd32;
    start = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (run_words < 3 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_words_before_reset", 64'(run_words), 64'(3));
    rst = 1'b1;
    #1;
    chk("abort_valid", 64'(bus.out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_data", 64'(bus.out_data), 64'(0));
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ndone  = 0;
    nvalid = 0;
    repeat (6) begin
      if (done) ndone++;
      if (bus.out_valid) nvalid++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(ndone), 64'(0));
    chk("abort_no_valid", 64'(nvalid), 64'(0));

    fill(3);
    in_map[0] = 8'hAB;
    hv = '{1, 1, 4, 0, 0, 1, 3, 1, 32'h000000AB, 32'h000000AB};
    run_map(hv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
